lfsr_mls_gen: RTL and testbench

// - Parametrised maximum-length-sequence (MLS) generator for the Red Pitaya DAC

---
 rtl/lfsr_pkg.sv | 52 +++++
 rtl/lfsr_core.sv | 38 +++
 rtl/lfsr_mls_gen.sv | 106 ++++++++++
 tb/tb_lfsr_mls_gen.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared types and helpers for the maximum-length-sequence generator.
// default_mask_f gives a maximal-length tap mask (bit i taps state[i]) for widths 3..32.
package lfsr_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } fsm_state_e;

   function automatic logic [32:0] period_f(input int w);
      return (33'd1 << w) - 33'd1;
   endfunction

   // Taps from the classic maximal-length table: term x^k maps to bit k-1.
   function automatic logic [31:0] default_mask_f(input int w);
      case (w)
         3:       return 32'h0000_0006;
         4:       return 32'h0000_000C;
         5:       return 32'h0000_0014;
         6:       return 32'h0000_0030;
         7:       return 32'h0000_0060;
         8:       return 32'h0000_00B8;
         9:       return 32'h0000_0110;
         10:      return 32'h0000_0240;
         11:      return 32'h0000_0500;
         12:      return 32'h0000_0829;
         13:      return 32'h0000_100D;
         14:      return 32'h0000_2015;
         15:      return 32'h0000_6000;
         16:      return 32'h0000_D008;
         17:      return 32'h0001_2000;
         18:      return 32'h0002_0400;
         19:      return 32'h0004_0023;
         20:      return 32'h0009_0000;
         21:      return 32'h0014_0000;
         22:      return 32'h0030_0000;
         23:      return 32'h0042_0000;
         24:      return 32'h00E1_0000;
         25:      return 32'h0120_0000;
         26:      return 32'h0200_0023;
         27:      return 32'h0400_0013;
         28:      return 32'h0900_0000;
         29:      return 32'h1400_0000;
         30:      return 32'h2000_0029;
         31:      return 32'h4800_0000;
         32:      return 32'h8020_0003;
         default: return 32'h0000_0000;
      endcase
   endfunction

endpackage

// File: rtl/lfsr_core.sv
// Fibonacci LFSR state register: shifts left, feedback enters bit 0.
// A zero seed is replaced by 1 so the all-zero lock-up state is unreachable.
module lfsr_core
   import lfsr_pkg::*;
#(
   parameter int unsigned          WIDTH_P = 10,
   parameter logic [WIDTH_P-1:0]   MASK_P  = WIDTH_P'(default_mask_f(WIDTH_P))
)(
   input  logic               clk,
   input  logic               srst,
   input  logic               load,
   input  logic [WIDTH_P-1:0] seed,
   input  logic               step,
   output logic [WIDTH_P-1:0] state
);

   localparam logic [WIDTH_P-1:0] ONE_C = WIDTH_P'(1);

   logic [WIDTH_P-1:0] r_state;
   logic               w_fb;
   logic [WIDTH_P-1:0] w_seed_safe;

   assign w_fb        = ^(r_state & MASK_P);
   assign w_seed_safe = (seed == '0) ? ONE_C : seed;

   always_ff @(posedge clk) begin
      if (srst) begin
         r_state <= ONE_C;
      end else if (load) begin
         r_state <= w_seed_safe;
      end else if (step) begin
         r_state <= {r_state[WIDTH_P-2:0], w_fb};
      end
   end

   assign state = r_state;

endmodule

// File: rtl/lfsr_mls_gen.sv
// MLS chip generator: FSM, period/repetition counters and the chip handshake.
// Handshake: a chip transfers on a cycle with valid_o & ready_i; while valid_o & !ready_i, sig_o and last_o hold.
module lfsr_mls_gen
   import lfsr_pkg::*;
#(
   parameter int unsigned          WIDTH_P = 10,
   parameter logic [WIDTH_P-1:0]   MASK_P  = WIDTH_P'(default_mask_f(WIDTH_P)),
   parameter int unsigned          REP_W_P = 16
)(
   input  logic               clk,
   input  logic               srst,
   input  logic               start_i,
   input  logic               stop_i,
   input  logic [WIDTH_P-1:0] seed_i,
   input  logic [REP_W_P-1:0] rep_i,
   output logic               sig_o,
   output logic               valid_o,
   input  logic               ready_i,
   output logic               last_o,
   output logic               busy_o,
   output logic               done_o,
   output fsm_state_e         dbg_state_o
);

   localparam logic [WIDTH_P-1:0] LAST_CNT = WIDTH_P'(period_f(WIDTH_P) - 33'd1);

   fsm_state_e         r_fsm;
   fsm_state_e         w_fsm_next;
   logic [WIDTH_P-1:0] r_chip_cnt;
   logic [REP_W_P-1:0] r_rep;
   logic [REP_W_P-1:0] r_rep_cnt;
   logic [WIDTH_P-1:0] w_lfsr_state;
   logic               w_load;
   logic               w_valid;
   logic               w_hs;
   logic               w_last;
   logic               w_final;

   assign w_load  = (r_fsm == IDLE) && start_i;
   assign w_valid = (r_fsm == RUN);
   assign w_hs    = w_valid && ready_i;
   assign w_last  = w_valid && (r_chip_cnt == LAST_CNT);
   // rep == 0 means continuous, so it never matches as a final period.
   assign w_final = w_hs && w_last && (r_rep != '0) && (r_rep_cnt == r_rep - REP_W_P'(1));

   always_comb begin
      w_fsm_next = r_fsm;
      case (r_fsm)
         IDLE:    if (start_i) w_fsm_next = RUN;
         RUN: begin
            if (stop_i)       w_fsm_next = IDLE;
            else if (w_final) w_fsm_next = DONE;
         end
         DONE:    w_fsm_next = IDLE;
         default: w_fsm_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         r_fsm <= IDLE;
      end else begin
         r_fsm <= w_fsm_next;
      end
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         r_chip_cnt <= '0;
         r_rep_cnt  <= '0;
         r_rep      <= '0;
      end else if (w_load) begin
         r_chip_cnt <= '0;
         r_rep_cnt  <= '0;
         r_rep      <= rep_i;
      end else if (w_hs) begin
         if (r_chip_cnt == LAST_CNT) begin
            r_chip_cnt <= '0;
            // Saturate so continuous mode can never alias onto a finite count.
            if (r_rep_cnt != '1) r_rep_cnt <= r_rep_cnt + REP_W_P'(1);
         end else begin
            r_chip_cnt <= r_chip_cnt + WIDTH_P'(1);
         end
      end
   end

   lfsr_core #(
      .WIDTH_P (WIDTH_P),
      .MASK_P  (MASK_P)
   ) u_core (
      .clk   (clk),
      .srst  (srst),
      .load  (w_load),
      .seed  (seed_i),
      .step  (w_hs),
      .state (w_lfsr_state)
   );

   assign sig_o       = w_lfsr_state[WIDTH_P-1];
   assign valid_o     = w_valid;
   assign last_o      = w_last;
   assign busy_o      = (r_fsm == RUN);
   assign done_o      = (r_fsm == DONE);
   assign dbg_state_o = r_fsm;

endmodule

// File: tb/tb_lfsr_mls_gen.sv
// Directed bench for lfsr_mls_gen: a 3-bit instance for exact chip patterns and
// handshake corners, and a default 10-bit instance for full-period sequence properties.
module tb_lfsr_mls_gen;
  import lfsr_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic srst;
  always #5 clk = ~clk;

  // ---------------- 3-bit instance ----------------
  logic        d3_start, d3_stop, d3_ready;
  logic [2:0]  d3_seed;
  logic [15:0] d3_rep;
  logic        d3_sig, d3_valid, d3_last, d3_busy, d3_done;
  fsm_state_e  d3_dbg;

  lfsr_mls_gen #(.WIDTH_P(3), .MASK_P(3'b110), .REP_W_P(16)) dut3 (
    .clk(clk), .srst(srst), .start_i(d3_start), .stop_i(d3_stop),
    .seed_i(d3_seed), .rep_i(d3_rep), .sig_o(d3_sig), .valid_o(d3_valid),
    .ready_i(d3_ready), .last_o(d3_last), .busy_o(d3_busy), .done_o(d3_done),
    .dbg_state_o(d3_dbg)
  );

  // ---------------- 10-bit default instance ----------------
  logic        d10_start, d10_stop, d10_ready;
  logic [9:0]  d10_seed;
  logic [15:0] d10_rep;
  logic        d10_sig, d10_valid, d10_last, d10_busy, d10_done;
  fsm_state_e  d10_dbg;

  lfsr_mls_gen dut10 (
    .clk(clk), .srst(srst), .start_i(d10_start), .stop_i(d10_stop),
    .seed_i(d10_seed), .rep_i(d10_rep), .sig_o(d10_sig), .valid_o(d10_valid),
    .ready_i(d10_ready), .last_o(d10_last), .busy_o(d10_busy), .done_o(d10_done),
    .dbg_state_o(d10_dbg)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [0:0] exp_q[$];
  logic [0:0] got_q[$];
  logic [0:0] lastq[$];
  int run_done;
  int run_stall_err;

  // Hand-computed W=3, mask 110, seed 1 sequence of output chips.
  logic pat [0:6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct packed {
    logic        srst;
    logic        start;
    logic        stop;
    logic        ready;
    logic [2:0]  seed;
    logic [15:0] rep;
    logic        sig;
    logic        valid;
    logic        last;
    logic        busy;
    logic        done;
  } vec_t;

  vec_t vq[$];

  // Start a W=3 run and collect accepted chips until done_o or a cycle budget.
  task automatic run3(input logic [2:0] seed, input logic [15:0] rep,
                      input bit rnd_ready, input int max_cyc);
    logic r, prev_stall, prev_sig, prev_last;
    got_q.delete();
    lastq.delete();
    run_done = 0;
    run_stall_err = 0;
    prev_stall = 1'b0;
    prev_sig = 1'b0;
    prev_last = 1'b0;
    d3_seed = seed;
    d3_rep = rep;
    d3_start = 1'b1;
    tick();
    d3_start = 1'b0;
    for (int c = 0; c < max_cyc; c++) begin
      if (prev_stall && (!d3_valid || d3_sig !== prev_sig || d3_last !== prev_last))
        run_stall_err++;
      if (d3_done) begin
        run_done++;
        break;
      end
      r = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      d3_ready = r;
      if (d3_valid && r) begin
        got_q.push_back(d3_sig);
        lastq.push_back(d3_last);
      end
      prev_stall = d3_valid && !r;
      prev_sig = d3_sig;
      prev_last = d3_last;
      tick();
    end
  endtask

  task automatic check_run3(input string tag, input int rep);
    chk({tag, ".chips"}, got_q.size(), rep * 7);
    exp_q.delete();
    for (int i = 0; i < rep * 7; i++) exp_q.push_back(pat[i % 7]);
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      chk($sformatf("%s.chip%0d", tag, i), got_q[i], exp_q[i]);
      chk($sformatf("%s.last%0d", tag, i), lastq[i], (i % 7) == 6);
    end
    chk({tag, ".done"}, run_done, 1);
    chk({tag, ".stall"}, run_stall_err, 0);
    tick();
    chk({tag, ".busy_after"}, d3_busy, 0);
    chk({tag, ".done_after"}, d3_done, 0);
    chk({tag, ".valid_after"}, d3_valid, 0);
  endtask

  initial begin
    int n, errs, dn;
    int n10, ones, lasts, last_idx, dup;
    logic chips10 [0:1022];
    logic seen [0:1023];
    logic [9:0] w;

    srst = 1'b1;
    d3_start = 1'b0; d3_stop = 1'b0; d3_ready = 1'b0; d3_seed = '0; d3_rep = '0;
    d10_start = 1'b0; d10_stop = 1'b0; d10_ready = 1'b0; d10_seed = '0; d10_rep = '0;
    repeat (2) tick();

    // srst start stop ready seed rep | sig valid last busy done
    vq.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    vq.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 3'd1, 16'd1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0});
    vq.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 16'd1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0});
    vq.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 16'd1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0});
    vq.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 16'd1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0});
    vq.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 16'd1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0});
    vq.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 16'd1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0});
    vq.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 16'd1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0});
    vq.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 16'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
    vq.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 16'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    vq.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 3'd1, 16'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    vq.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 3'd5, 16'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    vq.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 3'd4, 16'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0});
    vq.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 3'd4, 16'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0});
    vq.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 16'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0});
    vq.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 16'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0});
    vq.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 3'd1, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    vq.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});

    for (int i = 0; i < vq.size(); i++) begin
      srst = vq[i].srst;
      d3_start = vq[i].start;
      d3_stop = vq[i].stop;
      d3_ready = vq[i].ready;
      d3_seed = vq[i].seed;
      d3_rep = vq[i].rep;
      tick();
      chk($sformatf("vec%0d.sig", i), d3_sig, vq[i].sig);
      chk($sformatf("vec%0d.valid", i), d3_valid, vq[i].valid);
      chk($sformatf("vec%0d.last", i), d3_last, vq[i].last);
      chk($sformatf("vec%0d.busy", i), d3_busy, vq[i].busy);
      chk($sformatf("vec%0d.done", i), d3_done, vq[i].done);
    end
    srst = 1'b0;
    d3_start = 1'b0;
    d3_stop = 1'b0;
    chk("rst10.sig", d10_sig, 0);
    chk("rst10.valid", d10_valid, 0);

    // Three periods under random back-pressure.
    run3(3'd1, 16'd3, 1'b1, 500);
    check_run3("rep3", 3);

    // Zero seed behaves as seed 1.
    run3(3'd0, 16'd1, 1'b0, 100);
    check_run3("seed0", 1);

    // Continuous mode, stop raised together with the 100th handshake.
    d3_seed = 3'd1; d3_rep = 16'd0; d3_start = 1'b1;
    tick();
    d3_start = 1'b0;
    d3_ready = 1'b1;
    n = 0; errs = 0;
    for (int c = 0; c < 300; c++) begin
      if (!d3_valid) break;
      if (d3_sig !== pat[n % 7]) errs++;
      n++;
      if (n == 100) d3_stop = 1'b1;
      tick();
      d3_stop = 1'b0;
    end
    chk("stop.chips", n, 100);
    chk("stop.chip_err", errs, 0);
    chk("stop.busy", d3_busy, 0);
    chk("stop.sig_after_last_hs", d3_sig, pat[100 % 7]);
    dn = 0;
    for (int c = 0; c < 4; c++) begin
      if (d3_done) dn++;
      tick();
    end
    chk("stop.no_done", dn, 0);

    // Restart from a new seed (100): stream is the base pattern rotated by one.
    d3_seed = 3'd4; d3_rep = 16'd0; d3_start = 1'b1;
    tick();
    d3_start = 1'b0;
    errs = 0;
    for (int i = 0; i < 7; i++) begin
      if (d3_sig !== pat[(i + 6) % 7] || !d3_valid) errs++;
      tick();
    end
    chk("restart.chip_err", errs, 0);
    d3_stop = 1'b1;
    tick();
    d3_stop = 1'b0;
    chk("restart.stopped", d3_valid, 0);

    // Stop coinciding with the final last_o handshake: IDLE, no done_o.
    d3_seed = 3'd1; d3_rep = 16'd1; d3_start = 1'b1;
    tick();
    d3_start = 1'b0;
    d3_ready = 1'b1;
    repeat (6) tick();
    chk("stopfinal.last", d3_last, 1);
    d3_stop = 1'b1;
    tick();
    d3_stop = 1'b0;
    chk("stopfinal.valid", d3_valid, 0);
    chk("stopfinal.done", d3_done, 0);
    chk("stopfinal.busy", d3_busy, 0);
    tick();
    chk("stopfinal.done_late", d3_done, 0);
    d3_ready = 1'b0;

    // W=10 full period.
    d10_seed = 10'h2A5; d10_rep = 16'd1; d10_ready = 1'b1; d10_start = 1'b1;
    tick();
    d10_start = 1'b0;
    n10 = 0; ones = 0; lasts = 0; last_idx = -1; dn = 0;
    for (int c = 0; c < 1200; c++) begin
      if (d10_done) begin
        dn++;
        break;
      end
      if (d10_valid) begin
        if (n10 < 1023) chips10[n10] = d10_sig;
        if (d10_sig) ones++;
        if (d10_last) begin
          lasts++;
          last_idx = n10;
        end
        n10++;
      end
      tick();
    end
    chk("w10.chips", n10, 1023);
    chk("w10.ones", ones, 512);
    chk("w10.lasts", lasts, 1);
    chk("w10.last_idx", last_idx, 1022);
    chk("w10.done", dn, 1);
    dup = 1;
    if (n10 == 1023) begin
      dup = 0;
      for (int i = 0; i < 1024; i++) seen[i] = 1'b0;
      for (int i = 0; i < 1023; i++) begin
        w = '0;
        for (int j = 0; j < 10; j++) w = {w[8:0], chips10[(i + j) % 1023]};
        if (seen[w]) dup++;
        seen[w] = 1'b1;
      end
    end
    chk("w10.distinct_states", dup, 0);
    tick();
    chk("w10.busy_after", d10_busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
